fetch_issue_queue: RTL

- Producer end of the FE→ID instruction interface: buffers fetch-bus responses and drives the FE/ID register read by the ID stage aligner.
- Honours the ID back-pressure stall and the MA flush.
- Issues request credits to the fetch address generator so that no response is ever dropped.
- Discards stale responses still in flight when a flush occurs.

---
 rtl/fetch_issue_queue_if.sv | 29 ++
 rtl/fetch_issue_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_issue_queue_if.sv
// FE->ID fetch-response / FE-ID register bundle. The slave side is the queue;
// the master side is the fetch unit plus ID stage driving requests, responses and stall.
interface fetch_issue_queue_if;
  logic        s_flush_i;
  logic        s_stall_i;
  logic        s_req_issue_i;
  logic        s_issue_ok_o;
  logic        s_rsp_valid_i;
  logic [31:0] s_rsp_data_i;
  logic        s_rsp_hw_i;
  logic [2:0]  s_rsp_err_i;
  logic [1:0]  s_rsp_pred_i;
  logic [4:0]  s_feid_info_o;
  logic [31:0] s_feid_instr_o;
  logic [1:0]  s_feid_pred_o;
  logic        s_err_o;

  modport slave (
    input  s_flush_i, s_stall_i, s_req_issue_i,
    input  s_rsp_valid_i, s_rsp_data_i, s_rsp_hw_i, s_rsp_err_i, s_rsp_pred_i,
    output s_issue_ok_o, s_feid_info_o, s_feid_instr_o, s_feid_pred_o, s_err_o
  );

  modport master (
    output s_flush_i, s_stall_i, s_req_issue_i,
    output s_rsp_valid_i, s_rsp_data_i, s_rsp_hw_i, s_rsp_err_i, s_rsp_pred_i,
    input  s_issue_ok_o, s_feid_info_o, s_feid_instr_o, s_feid_pred_o, s_err_o
  );
endinterface

// File: rtl/fetch_issue_queue.sv
// Fetch response queue feeding the FE/ID register; empty-queue bypass gives 1-cycle latency.
// ID stall holds FE/ID while responses keep queueing; request credits keep the queue from overflowing.
module fetch_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input logic                s_clk_i,
  input logic                s_reset_i,
  fetch_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [31:0] data;
    logic        hw;
    logic [2:0]  err;
    logic [1:0]  pred;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [OW-1:0] out_q, out_d, disc_q, disc_d;
  logic          err_q, err_d;
  logic [4:0]    info_q, info_d;
  logic [31:0]   instr_q, instr_d;
  logic [1:0]    pred_q, pred_d;

  entry_t rsp, head;
  logic   issue_ok, acc, rsp_dec, pop, bypass, full, push_en, overflow;

  assign rsp  = '{data: bus.s_rsp_data_i, hw: bus.s_rsp_hw_i,
                  err: bus.s_rsp_err_i, pred: bus.s_rsp_pred_i};
  assign head = mem_q[rd_q];

  // Credit looks only at registered state so it never combinationally depends on the response.
  assign issue_ok = ((32'(occ_q) + 32'(out_q)) < 32'(DEPTH)) && (32'(out_q) < 32'(MAX_OUT));

  assign acc      = bus.s_rsp_valid_i && (disc_q == '0) && !bus.s_flush_i;
  assign rsp_dec  = bus.s_rsp_valid_i && (out_q != '0);
  assign full     = (occ_q == (AW+1)'(DEPTH));
  assign pop      = !bus.s_flush_i && !bus.s_stall_i && (occ_q != '0);
  assign bypass   = !bus.s_stall_i && (occ_q == '0) && acc;
  assign overflow = acc && !bypass && full && !pop;
  assign push_en  = acc && !bypass && !overflow;

  always_comb begin
    out_d  = out_q;
    disc_d = disc_q;
    err_d  = err_q;

    case ({bus.s_req_issue_i, rsp_dec})
      2'b10:   out_d = (out_q == OW'(MAX_OUT)) ? out_q : out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    // Everything already in flight at the flush is stale; a same-cycle issue is the redirect.
    if (bus.s_flush_i) begin
      disc_d = out_q - OW'(rsp_dec);
    end else if (bus.s_rsp_valid_i && (disc_q != '0)) begin
      disc_d = disc_q - 1'b1;
    end

    if ((bus.s_req_issue_i && !issue_ok) || (bus.s_rsp_valid_i && (out_q == '0)) || overflow) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q;
    if (bus.s_flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      occ_d = '0;
    end else begin
      rd_d = rd_q + AW'(pop);
      wr_d = wr_q + AW'(push_en);
      case ({push_en, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_comb begin
    info_d  = info_q;
    instr_d = instr_q;
    pred_d  = pred_q;
    if (bus.s_flush_i) begin
      info_d[0] = 1'b0;
      instr_d   = '0;
      pred_d    = '0;
    end else if (bus.s_stall_i) begin
      info_d = info_q;
    end else if (pop) begin
      info_d  = {head.err, head.hw, 1'b1};
      instr_d = head.data;
      pred_d  = head.pred;
    end else if (bypass) begin
      info_d  = {rsp.err, rsp.hw, 1'b1};
      instr_d = rsp.data;
      pred_d  = rsp.pred;
    end else begin
      info_d[0] = 1'b0;
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      out_q   <= '0;
      disc_q  <= '0;
      err_q   <= 1'b0;
      info_q  <= '0;
      instr_q <= '0;
      pred_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      occ_q   <= occ_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      err_q   <= err_d;
      info_q  <= info_d;
      instr_q <= instr_d;
      pred_q  <= pred_d;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (push_en) mem_q[wr_q] <= rsp;
  end

  assign bus.s_issue_ok_o   = issue_ok;
  assign bus.s_feid_info_o  = info_q;
  assign bus.s_feid_instr_o = instr_q;
  assign bus.s_feid_pred_o  = pred_q;
  assign bus.s_err_o        = err_q;
endmodule
